// File: rtl/chess_pkg.sv
// Shared chess accelerator definitions.
// Piece codes, material values and evaluator FSM states.
package chess_pkg;

    localparam int MAX_BOARDS     = 12;
    localparam int MAX_PAWN_MOVES = 12;

    localparam logic signed [7:0] EMPTY    = 8'sd0;
    localparam logic signed [7:0] WPAWN0   = 8'sd1;
    localparam logic signed [7:0] WPAWN7   = 8'sd8;
    localparam logic signed [7:0] WROOK0   = 8'sd9;
    localparam logic signed [7:0] WROOK9   = 8'sd18;
    localparam logic signed [7:0] WKNIGHT0 = 8'sd19;
    localparam logic signed [7:0] WKNIGHT9 = 8'sd28;
    localparam logic signed [7:0] WBISHOP0 = 8'sd29;
    localparam logic signed [7:0] WBISHOP9 = 8'sd38;
    localparam logic signed [7:0] WQUEEN0  = 8'sd39;
    localparam logic signed [7:0] WQUEEN8  = 8'sd47;
    localparam logic signed [7:0] WKING    = 8'sd48;
    localparam logic signed [7:0] BPAWN0   = -8'sd1;
    localparam logic signed [7:0] BROOK0   = -8'sd9;
    localparam logic signed [7:0] BKNIGHT0 = -8'sd19;
    localparam logic signed [7:0] BBISHOP0 = -8'sd29;
    localparam logic signed [7:0] BQUEEN0  = -8'sd39;
    localparam logic signed [7:0] BKING    = -8'sd48;

    localparam logic signed [31:0] VAL_PAWN   = 32'sd100;
    localparam logic signed [31:0] VAL_ROOK   = 32'sd500;
    localparam logic signed [31:0] VAL_KNIGHT = 32'sd320;
    localparam logic signed [31:0] VAL_BISHOP = 32'sd330;
    localparam logic signed [31:0] VAL_QUEEN  = 32'sd900;
    localparam logic signed [31:0] VAL_KING   = 32'sd20000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Signed material value of one square; unknown codes count as zero.
    function automatic logic signed [31:0] piece_value(
        input logic signed [7:0] code
    );
        logic [7:0]         mag;
        logic signed [31:0] v;
        mag = code[7] ? 8'(-code) : 8'(code);
        v   = 32'sd0;
        if (mag >= 8'(WPAWN0) && mag <= 8'(WPAWN7))
            v = VAL_PAWN;
        else if (mag >= 8'(WROOK0) && mag <= 8'(WROOK9))
            v = VAL_ROOK;
        else if (mag >= 8'(WKNIGHT0) && mag <= 8'(WKNIGHT9))
            v = VAL_KNIGHT;
        else if (mag >= 8'(WBISHOP0) && mag <= 8'(WBISHOP9))
            v = VAL_BISHOP;
        else if (mag >= 8'(WQUEEN0) && mag <= 8'(WQUEEN8))
            v = VAL_QUEEN;
        else if (mag == 8'(WKING))
            v = VAL_KING;
        return code[7] ? -v : v;
    endfunction

endpackage

// File: rtl/board_eval_word_material.sv
// Material sum of one 32-bit board word.
// Four squares, lowest square in the lowest byte.
module word_material
    import chess_pkg::*;
(
    input  logic [31:0]        i_word,
    output logic signed [31:0] o_sum
);

    assign o_sum = piece_value(i_word[7:0])
                 + piece_value(i_word[15:8])
                 + piece_value(i_word[23:16])
                 + piece_value(i_word[31:24]);

endmodule

// File: rtl/board_eval.sv
// Material evaluator for generated candidate boards.
// Reads boards over Avalon, writes scores, tracks best for white.
module board_eval #(
    parameter int MAX_BOARDS = chess_pkg::MAX_BOARDS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    import chess_pkg::*;

    state_t             r_state;
    logic [31:0]        r_src;
    logic [31:0]        r_cnt;
    logic [31:0]        r_dst;
    logic [31:0]        r_rd_addr;
    logic [31:0]        r_wr_addr;
    logic [31:0]        r_ncnt;
    logic [31:0]        r_board;
    logic [31:0]        r_scored;
    logic [31:0]        r_best_idx;
    logic signed [31:0] r_best_score;
    logic signed [31:0] r_acc;
    logic [3:0]         r_word;
    logic               r_mread;
    logic               r_mwrite;
    logic [31:0]        r_maddr;
    logic [31:0]        r_mwdata;

    logic               w_reg0;
    logic               w_start;
    logic [31:0]        w_clamp;
    logic signed [31:0] w_sum;
    logic signed [31:0] w_next_acc;
    logic [31:0]        w_rdata;

    assign w_reg0     = (slave_address == 4'd0);
    assign w_start    = slave_write && w_reg0 && (r_state == ST_IDLE);
    assign w_clamp    = (r_cnt > 32'(MAX_BOARDS)) ? 32'(MAX_BOARDS) : r_cnt;
    assign w_next_acc = r_acc + w_sum;

    // Status accesses stall until the run has finished.
    assign slave_waitrequest = (slave_read || slave_write) && w_reg0
                             && (r_state != ST_IDLE);

    assign master_address   = r_maddr;
    assign master_read      = r_mread;
    assign master_write     = r_mwrite;
    assign master_writedata = r_mwdata;
    assign slave_readdata   = w_rdata;

    word_material u_word_material (
        .i_word (master_readdata),
        .o_sum  (w_sum)
    );

    // Host-programmable configuration, latched into the run at start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src <= '0;
            r_cnt <= '0;
            r_dst <= '0;
        end else if (slave_write) begin
            case (slave_address)
                4'd1:    r_src <= slave_writedata;
                4'd2:    r_cnt <= slave_writedata;
                4'd3:    r_dst <= slave_writedata;
                default: ;
            endcase
        end
    end

    // Register read mux; idle bus returns zero.
    always_comb begin
        w_rdata = '0;
        if (slave_read) begin
            case (slave_address)
                4'd0:    w_rdata = r_scored;
                4'd1:    w_rdata = r_src;
                4'd2:    w_rdata = r_cnt;
                4'd3:    w_rdata = r_dst;
                4'd4:    w_rdata = r_best_idx;
                4'd5:    w_rdata = $unsigned(r_best_score);
                default: w_rdata = '0;
            endcase
        end
    end

    // Board walk: one outstanding read, one score write per board.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_ncnt       <= '0;
            r_board      <= '0;
            r_scored     <= '0;
            r_best_idx   <= '1;
            r_best_score <= 32'sh8000_0000;
            r_acc        <= '0;
            r_word       <= '0;
            r_mread      <= 1'b0;
            r_mwrite     <= 1'b0;
            r_maddr      <= '0;
            r_mwdata     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_rd_addr    <= r_src;
                        r_wr_addr    <= r_dst;
                        r_ncnt       <= w_clamp;
                        r_board      <= '0;
                        r_scored     <= '0;
                        r_best_idx   <= '1;
                        r_best_score <= 32'sh8000_0000;
                        r_acc        <= '0;
                        r_word       <= '0;
                        if (w_clamp == 32'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_maddr <= r_src;
                            r_mread <= 1'b1;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (!master_waitrequest) begin
                        r_mread   <= 1'b0;
                        r_rd_addr <= r_rd_addr + 32'd4;
                        r_state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        r_acc <= w_next_acc;
                        if (r_word == 4'd15) begin
                            r_maddr  <= r_wr_addr;
                            r_mwdata <= $unsigned(w_next_acc);
                            r_mwrite <= 1'b1;
                            r_state  <= ST_WR_REQ;
                        end else begin
                            r_word  <= r_word + 4'd1;
                            r_maddr <= r_rd_addr;
                            r_mread <= 1'b1;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (!master_waitrequest) begin
                        r_mwrite  <= 1'b0;
                        r_wr_addr <= r_wr_addr + 32'd4;
                        r_scored  <= r_scored + 32'd1;
                        r_board   <= r_board + 32'd1;
                        if (r_acc > r_best_score) begin
                            r_best_idx   <= r_board;
                            r_best_score <= r_acc;
                        end
                        if (r_board + 32'd1 < r_ncnt) begin
                            r_acc   <= '0;
                            r_word  <= '0;
                            r_maddr <= r_rd_addr;
                            r_mread <= 1'b1;
                            r_state <= ST_RD_REQ;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_eval.sv
// Scoreboard bench for board_eval.
// Directed boards, SDRAM model with optional stalls.
module tb_board_eval;

    localparam logic [31:0] SRC = 32'h0000_1000;
    localparam logic [31:0] DST = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    always #5 clk = ~clk;

    board_eval #(.MAX_BOARDS(12)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wexp_t;

    logic [31:0] mem [0:4095];
    logic [7:0]  brd [64];
    wexp_t       exp_wr [$];
    logic [31:0] exp_rd_v [$];
    string       exp_rd_n [$];

    int checks = 0;
    int errors = 0;
    int stall = 0;
    int stall_cnt = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_traffic = 0;
    int t_start = 0;
    bit lat_en = 1'b0;

    logic        pend_rd = 1'b0;
    logic        pend_wr = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pend_data = '0;
    logic        hold_v = 1'b0;
    logic [65:0] hold_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM model: data one cycle after accept, optional fixed stall.
    always @(posedge clk) begin
        #1;
        master_readdatavalid = pend_rd;
        master_readdata = pend_rd ? mem[pend_addr[13:2]] : 32'h0;
        if (pend_wr) mem[pend_addr[13:2]] = pend_data;
        if ((master_read || master_write) && stall_cnt < stall) begin
            master_waitrequest = 1'b1;
            stall_cnt = stall_cnt + 1;
        end else begin
            master_waitrequest = 1'b0;
            stall_cnt = 0;
        end
    end

    // Monitor: bus accepts, stall stability, write and read scoreboards.
    always @(negedge clk) begin : mon
        wexp_t       e;
        logic [65:0] q;
        logic [31:0] v;
        string       nm;
        pend_rd   = rst_n && master_read && !master_waitrequest;
        pend_wr   = rst_n && master_write && !master_waitrequest;
        pend_addr = master_address;
        pend_data = master_writedata;
        if (pend_rd) n_rd = n_rd + 1;
        if (master_read || master_write) n_traffic = n_traffic + 1;
        q = {master_address, master_read, master_write, master_writedata};
        if (hold_v) begin
            checks = checks + 1;
            if (q !== hold_q) begin
                errors = errors + 1;
                $display("FAIL stall_hold got %h want %h", q, hold_q);
            end
        end
        hold_v = rst_n && master_waitrequest && (master_read || master_write);
        hold_q = q;
        if (pend_wr) begin
            checks = checks + 1;
            if (exp_wr.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write addr %h data %h",
                         master_address, master_writedata);
            end else begin
                e = exp_wr.pop_front();
                if (master_address !== e.a || master_writedata !== e.d) begin
                    errors = errors + 1;
                    $display("FAIL score_write got %h@%h want %h@%h",
                             master_writedata, master_address, e.d, e.a);
                end
            end
            if (lat_en) begin
                lat_en = 1'b0;
                checks = checks + 1;
                if (cyc + 1 - t_start != 33) begin
                    errors = errors + 1;
                    $display("FAIL board_latency got %0d want 33",
                             cyc + 1 - t_start);
                end
            end
        end
        if (rst_n && slave_read && !slave_waitrequest) begin
            checks = checks + 1;
            if (exp_rd_v.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_read data %h", slave_readdata);
            end else begin
                v  = exp_rd_v.pop_front();
                nm = exp_rd_n.pop_front();
                if (slave_readdata !== v) begin
                    errors = errors + 1;
                    $display("FAIL %s got %h want %h", nm, slave_readdata, v);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_accept(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!slave_waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s timeout waiting for slave", nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bit ok;
        @(posedge clk);
        #1;
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        wait_accept("slave_write", ok);
        if (a == 4'd0) t_start = cyc;
        slave_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp,
                      input string nm);
        bit ok;
        @(posedge clk);
        #1;
        exp_rd_v.push_back(exp);
        exp_rd_n.push_back(nm);
        slave_address = a;
        slave_read    = 1'b1;
        wait_accept(nm, ok);
        if (!ok) begin
            void'(exp_rd_v.pop_back());
            void'(exp_rd_n.pop_back());
        end
        slave_read = 1'b0;
    endtask

    task automatic run(input logic [31:0] cnt, input logic [31:0] scored);
        wr(4'd1, SRC);
        wr(4'd2, cnt);
        wr(4'd3, DST);
        wr(4'd0, 32'd0);
        rd(4'd0, scored, "status");
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wexp_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic clear_brd();
        for (int i = 0; i < 64; i++) brd[i] = 8'h00;
    endtask

    task automatic std_brd();
        int back [8];
        back = '{9, 19, 29, 39, 48, 30, 20, 10};
        clear_brd();
        for (int i = 0; i < 8; i++) begin
            brd[i]      = 8'(-back[i]);
            brd[8 + i]  = 8'(-(i + 1));
            brd[48 + i] = 8'(i + 1);
            brd[56 + i] = 8'(back[i]);
        end
    endtask

    task automatic store_brd(input logic [31:0] addr);
        for (int w = 0; w < 16; w++)
            mem[addr[13:2] + 12'(w)] = {brd[4*w+3], brd[4*w+2],
                                        brd[4*w+1], brd[4*w]};
    endtask

    task automatic three_brds();
        clear_brd();
        brd[5]  = 8'd48;
        brd[60] = 8'(-48);
        brd[10] = 8'd1;
        store_brd(SRC);
        clear_brd();
        brd[20] = 8'(-9);
        brd[0]  = 8'd49;
        brd[1]  = 8'(-100);
        store_brd(SRC + 32'd64);
        clear_brd();
        brd[63] = 8'd8;
        brd[30] = 8'h80;
        store_brd(SRC + 32'd128);
        push_wr(DST,          32'd100);
        push_wr(DST + 32'd4,  32'hFFFF_FE0C);
        push_wr(DST + 32'd8,  32'd100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit ok;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {29'd0, master_read, master_write,
                            slave_waitrequest}, 32'd0);
        chk("rst_maddr", master_address, 32'd0);
        chk("rst_mwdata", master_writedata, 32'd0);
        chk("rst_sreaddata", slave_readdata, 32'd0);
        rst_n = 1'b1;
        rd(4'd4, 32'hFFFF_FFFF, "rst_best_idx");
        rd(4'd5, 32'h8000_0000, "rst_best_score");

        std_brd();
        store_brd(SRC);
        push_wr(DST, 32'd0);
        wr(4'd1, SRC);
        wr(4'd2, 32'd1);
        wr(4'd3, DST);
        rd(4'd1, SRC, "reg_src");
        rd(4'd2, 32'd1, "reg_cnt");
        rd(4'd3, DST, "reg_dst");
        base = n_rd;
        lat_en = 1'b1;
        wr(4'd0, 32'd0);
        rd(4'd0, 32'd1, "std_status");
        rd(4'd4, 32'd0, "std_best_idx");
        rd(4'd5, 32'd0, "std_best_score");
        chk("std_reads", n_rd - base, 32'd16);

        brd[3] = 8'h00;
        store_brd(SRC);
        push_wr(DST, 32'd900);
        run(32'd1, 32'd1);
        rd(4'd5, 32'd900, "noq_best_score");

        three_brds();
        base = n_rd;
        run(32'd3, 32'd3);
        rd(4'd4, 32'd0, "tie_best_idx");
        rd(4'd5, 32'd100, "tie_best_score");
        chk("three_reads", n_rd - base, 32'd48);

        stall = 5;
        three_brds();
        base = n_rd;
        run(32'd3, 32'd3);
        rd(4'd4, 32'd0, "stall_best_idx");
        rd(4'd5, 32'd100, "stall_best_score");
        chk("stall_reads", n_rd - base, 32'd48);
        stall = 0;

        base = n_traffic;
        run(32'd0, 32'd0);
        chk("zero_traffic", n_traffic - base, 32'd0);
        rd(4'd4, 32'hFFFF_FFFF, "zero_best_idx");
        rd(4'd5, 32'h8000_0000, "zero_best_score");

        for (int n = 0; n < 20; n++) begin
            clear_brd();
            for (int s = 0; s < n; s++) brd[s] = 8'd1;
            store_brd(SRC + 32'(64 * n));
            if (n < 12) push_wr(DST + 32'(4 * n), 32'(100 * n));
        end
        run(32'd20, 32'd12);
        rd(4'd2, 32'd20, "clamp_reg_cnt");
        rd(4'd4, 32'd11, "clamp_best_idx");
        rd(4'd5, 32'd1100, "clamp_best_score");

        std_brd();
        brd[3] = 8'h00;
        store_brd(SRC);
        wr(4'd1, SRC);
        wr(4'd2, 32'd1);
        wr(4'd3, DST);
        base = n_rd;
        wr(4'd0, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_rd - base >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reset_wait_reads", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_strobes", {30'd0, master_read, master_write}, 32'd0);
        rd(4'd1, 32'd0, "reset_src");
        rd(4'd2, 32'd0, "reset_cnt");
        rd(4'd3, 32'd0, "reset_dst");
        rd(4'd4, 32'hFFFF_FFFF, "reset_best_idx");
        rd(4'd5, 32'h8000_0000, "reset_best_score");
        rd(4'd0, 32'd0, "reset_status");
        repeat (40) @(posedge clk);
        push_wr(DST, 32'd900);
        run(32'd1, 32'd1);
        rd(4'd4, 32'd0, "rerun_best_idx");
        rd(4'd5, 32'd900, "rerun_best_score");

        repeat (5) @(posedge clk);
        #1;
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd_v.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
